aesl_deadlock_report_ctrl: RTL
==============================

// Module: aesl_deadlock_report_ctrl
// PURPOSE
// - Consumer end of the dataflow deadlock monitor: takes its per-cycle block flag and
//   axis_block_info vector, confirms a stall persists, then emits one report record per
//   stall episode over a valid/ready handshake to the sim logger / status regs.
// - Sits beside each AESL deadlock monitor instance in the co-sim wrapper.
// - Filters single-cycle false alarms.
// - Keeps a sticky deadlock flag and a saturating count of episodes reported.
// PARAMETERS
// - INFO_W          4    width of axis_block_info (2 bits per AXIS channel)
// - CONFIRM_CYCLES  16   consecutive blocked cycles needed to confirm (1..2^CNT_W-1)
// - CNT_W           16   width of confirm counter and rpt_cycles
// PORTS
// - clock            in   1       single clock, rising edge
// - reset            in   1       asynchronous, active-high
// - clear            in   1       sync soft clear (FSM, flag, counters)
// - block            in   1       monitor's "deadlock observed this cycle"
// - axis_block_info  in   INFO_W  monitor's per-channel block code, valid when block=1
// - rpt_valid        out  1       report record available
// - rpt_ready        in   1       logger accepts record
// - rpt_info         out  INFO_W  confirmed channel code
// - rpt_cycles       out  CNT_W   blocked cycles counted at confirmation
// - deadlock         out  1       sticky: at least one confirmed episode
// - rpt_count        out  8       episodes handed off, saturates at 255
// BEHAVIOUR
// - Reset (async assert, sync release): FSM=IDLE, all outputs 0, counter 0, snapshot 0.
// - FSM states: IDLE, CONFIRM, REPORT, HOLD.
// - IDLE
//   - block=1 -> CONFIRM; cnt<=1; snap<=axis_block_info.
//   - else stay IDLE.
// - CONFIRM
//   - block=0 -> IDLE; cnt<=0.
//   - block=1 and info!=snap -> restart: cnt<=1, snap<=info.
//   - block=1 and info==snap: cnt<=cnt+1.
//   - When cnt+1==CONFIRM_CYCLES (or CONFIRM_CYCLES==1 on IDLE entry), on that same edge:
//     -> REPORT; rpt_valid<=1; rpt_info<=snap; rpt_cycles<=CONFIRM_CYCLES; deadlock<=1.
//   - rpt_valid is therefore high after the edge sampling the CONFIRM_CYCLES-th
//     consecutive identical block=1 cycle.
// - REPORT
//   - rpt_valid, rpt_info and rpt_cycles stay stable until rpt_valid&rpt_ready.
//   - The block input is ignored while in REPORT.
//   - Handshake -> HOLD; rpt_valid<=0; rpt_count<=sat(rpt_count+1).
// - HOLD
//   - Wait for block=0 (one sampled cycle), then -> IDLE.
//   - A stall that is still present must not produce a second report.
// - clear
//   - Highest priority after reset: FSM=IDLE, rpt_valid=0, deadlock=0, rpt_count=0, cnt=0.
//   - This is the only case where rpt_valid may drop without a handshake.
//   - clear together with a handshake: the clear wins and the count is not incremented.
// - rpt_ready while rpt_valid=0 has no effect.
// - rpt_count saturates at 255.
// - cnt never wraps; it is bounded by CONFIRM_CYCLES.
// CONFIGURATION
// - AESL_DEADLOCK_AUTOCLR_EN defined:
//   - deadlock clears on the HOLD->IDLE transition, so the stall is treated as transient.
//   - rpt_count is unaffected.
// - AESL_DEADLOCK_AUTOCLR_EN undefined:
//   - deadlock is sticky until clear or reset.
// TESTING
// - Tests use CONFIRM_CYCLES=4.
// - T1: block=1, info=4'hE for 4 cycles, rpt_ready=1
//       -> rpt_valid for 1 cycle after the 4th edge; rpt_info=E; rpt_cycles=4;
//          deadlock=1; rpt_count=1.
// - T2: block=1 for 3 cycles, then 0
//       -> no rpt_valid; deadlock=0; FSM back to IDLE.
// - T3: info E,E,D,D,D,D with block=1
//       -> counter restarts at D; report appears after the 4th D with rpt_info=D.
// - T4: confirmed report with rpt_ready=0 for 10 cycles, while block toggles
//       -> rpt_valid and payload stay stable; handshake on the 11th cycle; rpt_count=1.
// - T5: block held 1 for 50 cycles, rpt_ready=1
//       -> exactly one report. Drop block for 1 cycle, re-raise for 4 cycles
//       -> second report; rpt_count=2. With AUTOCLR_EN, deadlock=0 in the gap cycle.
// - T6: async reset mid-REPORT -> all outputs 0 immediately;
//       clear concurrent with a handshake -> rpt_count=0, deadlock=0.

Source files
------------

// File: rtl/aesl_deadlock_report_ctrl.sv
// aesl_deadlock_report_ctrl
// Consumer end of the dataflow deadlock monitor. It watches the per-cycle block
// flag and channel code, and confirms a stall once the same code has been seen
// for CONFIRM_CYCLES consecutive cycles. It then hands off exactly one report
// record per stall episode over a valid/ready handshake.
// A sticky deadlock flag and a saturating episode count are also maintained.
// Optional build macro: AESL_DEADLOCK_AUTOCLR_EN. When it is defined, the
// deadlock flag drops again once the stall has gone away (HOLD -> IDLE).
module aesl_deadlock_report_ctrl #(
    parameter int INFO_W         = 4,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              block,
    input  logic [INFO_W-1:0] axis_block_info,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [INFO_W-1:0] rpt_info,
    output logic [CNT_W-1:0]  rpt_cycles,
    output logic              deadlock,
    output logic [7:0]        rpt_count
);

    localparam logic [CNT_W-1:0] CONFIRM_VAL = CNT_W'(CONFIRM_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        REPORT  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [INFO_W-1:0] snap;

    // Stall confirmation, report handshake and status bookkeeping in one FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            snap       <= '0;
            rpt_valid  <= 1'b0;
            rpt_info   <= '0;
            rpt_cycles <= '0;
            deadlock   <= 1'b0;
            rpt_count  <= 8'd0;
        end else if (clear) begin
            // Soft clear beats everything, including a simultaneous handshake
            state      <= IDLE;
            cnt        <= '0;
            snap       <= '0;
            rpt_valid  <= 1'b0;
            rpt_info   <= '0;
            rpt_cycles <= '0;
            deadlock   <= 1'b0;
            rpt_count  <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (block) begin
                        snap <= axis_block_info;
                        if (CONFIRM_VAL == CNT_ONE) begin
                            // A one-cycle confirmation window reports on entry
                            state      <= REPORT;
                            cnt        <= '0;
                            rpt_valid  <= 1'b1;
                            rpt_info   <= axis_block_info;
                            rpt_cycles <= CONFIRM_VAL;
                            deadlock   <= 1'b1;
                        end else begin
                            state <= CONFIRM;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                CONFIRM: begin
                    if (!block) begin
                        // A stall that goes away early was a false alarm
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (axis_block_info != snap) begin
                        // A different channel code starts a fresh episode
                        cnt  <= CNT_ONE;
                        snap <= axis_block_info;
                    end else if (cnt + CNT_ONE == CONFIRM_VAL) begin
                        state      <= REPORT;
                        cnt        <= '0;
                        rpt_valid  <= 1'b1;
                        rpt_info   <= snap;
                        rpt_cycles <= CONFIRM_VAL;
                        deadlock   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                REPORT: begin
                    // The payload stays frozen and block is ignored until accepted
                    if (rpt_ready) begin
                        state     <= HOLD;
                        rpt_valid <= 1'b0;
                        if (rpt_count != 8'hFF) begin
                            rpt_count <= rpt_count + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    // The stall must clear before another episode can be reported
                    if (!block) begin
                        state <= IDLE;
`ifdef AESL_DEADLOCK_AUTOCLR_EN
                        deadlock <= 1'b0;
`else
                        deadlock <= deadlock;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
